// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scheduler: ROM address width,
// sprite ROM layout constants, the per-slot record and the update FSM states.
package sprite_pkg;

   localparam int ADDR_W = 18;

   localparam int RUNNER3_BASE = 207867;
   localparam int RUNNER4_BASE = 216139;
   localparam int RUNNER_W     = 88;
   localparam int RUNNER_H     = 94;
   localparam int CLOUD_BASE   = 44420;
   localparam int CLOUD_W      = 92;
   localparam int CLOUD_H      = 27;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_UPDATE = 1'b1
   } upd_state_t;

   typedef struct packed {
      logic              active;
      logic [ADDR_W-1:0] base0;
      logic [ADDR_W-1:0] base1;
      logic [7:0]        w;
      logic [7:0]        h;
      logic [9:0]        x;
      logic [9:0]        y;
      logic [3:0]        dx;
      logic [7:0]        anim_cnt;
      logic              fsel;
   } obj_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test and ROM address for one sprite slot against the
// current pixel; bounds are exclusive at x+w / y+h, evaluated at 11 bits.
module sprite_hit
   import sprite_pkg::*;
(
   input  logic              active,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic [7:0]        w,
   input  logic [7:0]        h,
   input  logic [ADDR_W-1:0] base,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic              hit,
   output logic [ADDR_W-1:0] addr
);

   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [7:0]  off_x;
   logic [7:0]  off_y;
   logic [15:0] row_off;

   always_comb begin
      x_end   = {1'b0, x} + {3'b000, w};
      y_end   = {1'b0, y} + {3'b000, h};
      hit     = active && (DrawX >= x) && ({1'b0, DrawX} < x_end)
                       && (DrawY >= y) && ({1'b0, DrawY} < y_end);
      // Offsets only matter on a hit, where they are below w/h and fit in 8 bits.
      off_x   = DrawX[7:0] - x[7:0];
      off_y   = DrawY[7:0] - y[7:0];
      row_off = {8'h00, off_y} * {8'h00, w};
      addr    = base + ADDR_W'(row_off) + ADDR_W'(off_x);
   end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite slot state, per-frame motion/animation sequencer and per-pixel ROM
// address scheduler. Define SPRITE_WRAP_EN to wrap sprites to SCREEN_W.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int NUM_OBJ  = 4,
   parameter int ANIM_DIV = 5,
   parameter int SCREEN_W = 640
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_tick,
   input  logic                       pix_en,
   input  logic [9:0]                 DrawX,
   input  logic [9:0]                 DrawY,
   input  logic                       cfg_we,
   input  logic [$clog2(NUM_OBJ)-1:0] cfg_id,
   input  logic                       cfg_active,
   input  logic [ADDR_W-1:0]          cfg_base0,
   input  logic [ADDR_W-1:0]          cfg_base1,
   input  logic [7:0]                 cfg_w,
   input  logic [7:0]                 cfg_h,
   input  logic [9:0]                 cfg_x,
   input  logic [9:0]                 cfg_y,
   input  logic [3:0]                 cfg_dx,
   output logic [ADDR_W-1:0]          rom_addr,
   output logic                       rom_req,
   output logic [$clog2(NUM_OBJ)-1:0] hit_id,
   output logic                       hit_valid_d,
   output logic [$clog2(NUM_OBJ)-1:0] hit_id_d,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_OBJ);
   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_OBJ - 1);

   upd_state_t        state, state_nx;
   logic [ID_W-1:0]   idx, idx_nx;
   logic              upd_en;
   obj_t              slots [NUM_OBJ];
   obj_t              cfg_obj;
   logic [NUM_OBJ-1:0] slot_hit;
   logic [ADDR_W-1:0] slot_addr [NUM_OBJ];
   logic              any_hit;
   logic [ID_W-1:0]   win_id;
   logic [ADDR_W-1:0] win_addr;

   function automatic obj_t step_obj(input obj_t o);
      obj_t n;
      n = o;
      if (o.x >= {6'b000000, o.dx}) begin
         n.x = o.x - {6'b000000, o.dx};
      end else begin
`ifdef SPRITE_WRAP_EN
         n.x = 10'(SCREEN_W);
`else
         n.active = 1'b0;
`endif
      end
      if (o.anim_cnt == 8'(ANIM_DIV - 1)) begin
         n.anim_cnt = 8'd0;
         n.fsel     = ~o.fsel;
      end else begin
         n.anim_cnt = o.anim_cnt + 8'd1;
      end
      return n;
   endfunction

   // Update FSM: one slot per cycle for NUM_OBJ cycles after a frame tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         ST_IDLE: begin
            if (frame_tick) begin
               state_nx = ST_UPDATE;
               idx_nx   = '0;
            end
         end
         ST_UPDATE: begin
            if (idx == LAST_IDX) begin
               state_nx = ST_IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + ID_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state == ST_UPDATE);
      upd_en = (state == ST_UPDATE);
   end

   always_comb begin
      cfg_obj          = '0;
      cfg_obj.active   = cfg_active;
      cfg_obj.base0    = cfg_base0;
      cfg_obj.base1    = cfg_base1;
      cfg_obj.w        = cfg_w;
      cfg_obj.h        = cfg_h;
      cfg_obj.x        = cfg_x;
      cfg_obj.y        = cfg_y;
      cfg_obj.dx       = cfg_dx;
   end

   // A config write to the slot being updated wins; that slot's step is dropped.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_OBJ; i++) slots[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (cfg_we && cfg_id == ID_W'(i)) begin
               slots[i] <= cfg_obj;
            end else if (upd_en && idx == ID_W'(i) && slots[i].active) begin
               slots[i] <= step_obj(slots[i]);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
      sprite_hit u_hit (
         .active (slots[g].active),
         .x      (slots[g].x),
         .y      (slots[g].y),
         .w      (slots[g].w),
         .h      (slots[g].h),
         .base   (slots[g].fsel ? slots[g].base1 : slots[g].base0),
         .DrawX  (DrawX),
         .DrawY  (DrawY),
         .hit    (slot_hit[g]),
         .addr   (slot_addr[g])
      );
   end

   always_comb begin
      any_hit  = 1'b0;
      win_id   = '0;
      win_addr = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (slot_hit[i]) begin
            any_hit  = 1'b1;
            win_id   = ID_W'(i);
            win_addr = slot_addr[i];
         end
      end
   end

   // rom_req is a valid-only strobe (no ready): the ROM accepts every request;
   // rom_addr and hit_id hold their last value while rom_req is low.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr    <= '0;
         rom_req     <= 1'b0;
         hit_id      <= '0;
         hit_valid_d <= 1'b0;
         hit_id_d    <= '0;
      end else begin
         if (pix_en && any_hit) begin
            rom_addr <= win_addr;
            rom_req  <= 1'b1;
            hit_id   <= win_id;
         end else begin
            rom_req  <= 1'b0;
         end
         hit_valid_d <= rom_req;
         hit_id_d    <= hit_id;
      end
   end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler against a slot-level reference
// model; honours SPRITE_WRAP_EN for the wrap expectation.
module tb_sprite_scheduler;
   import sprite_pkg::*;

   localparam int NUM_OBJ  = 4;
   localparam int ANIM_DIV = 5;
   localparam int SCREEN_W = 640;

   logic              Clk;
   logic              Reset;
   logic              frame_tick;
   logic              pix_en;
   logic [9:0]        DrawX, DrawY;
   logic              cfg_we;
   logic [1:0]        cfg_id;
   logic              cfg_active;
   logic [ADDR_W-1:0] cfg_base0, cfg_base1;
   logic [7:0]        cfg_w, cfg_h;
   logic [9:0]        cfg_x, cfg_y;
   logic [3:0]        cfg_dx;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_req;
   logic [1:0]        hit_id;
   logic              hit_valid_d;
   logic [1:0]        hit_id_d;
   logic              busy;

   sprite_scheduler #(.NUM_OBJ(NUM_OBJ), .ANIM_DIV(ANIM_DIV), .SCREEN_W(SCREEN_W)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pix_en(pix_en),
      .DrawX(DrawX), .DrawY(DrawY), .cfg_we(cfg_we), .cfg_id(cfg_id),
      .cfg_active(cfg_active), .cfg_base0(cfg_base0), .cfg_base1(cfg_base1),
      .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dx(cfg_dx),
      .rom_addr(rom_addr), .rom_req(rom_req), .hit_id(hit_id),
      .hit_valid_d(hit_valid_d), .hit_id_d(hit_id_d), .busy(busy)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: slot records as plain integers
   int m_act[NUM_OBJ], m_b0[NUM_OBJ], m_b1[NUM_OBJ], m_w[NUM_OBJ], m_h[NUM_OBJ];
   int m_x[NUM_OBJ], m_y[NUM_OBJ], m_dx[NUM_OBJ], m_anim[NUM_OBJ], m_fsel[NUM_OBJ];
   int upd_ptr;
   int m_addr, m_id, m_req;
   logic [31:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_OBJ; i++) begin
         m_act[i] = 0; m_b0[i] = 0; m_b1[i] = 0; m_w[i] = 0; m_h[i] = 0;
         m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_anim[i] = 0; m_fsel[i] = 0;
      end
      upd_ptr = -1;
   endtask

   task automatic model_move(input int s);
      if (m_x[s] >= m_dx[s]) m_x[s] = m_x[s] - m_dx[s];
`ifdef SPRITE_WRAP_EN
      else m_x[s] = SCREEN_W;
`else
      else m_act[s] = 0;
`endif
      m_anim[s] = m_anim[s] + 1;
      if (m_anim[s] == ANIM_DIV) begin
         m_anim[s] = 0;
         m_fsel[s] = 1 - m_fsel[s];
      end
   endtask

   task automatic model_step();
      int cur;
      if (Reset) begin
         model_reset();
         return;
      end
      cur = upd_ptr;
      if (cur >= 0) begin
         if (!(cfg_we && int'(cfg_id) == cur) && m_act[cur] != 0) model_move(cur);
         upd_ptr = (cur == NUM_OBJ - 1) ? -1 : cur + 1;
      end else if (frame_tick) begin
         upd_ptr = 0;
      end
      if (cfg_we) begin
         m_act[cfg_id] = int'(cfg_active); m_b0[cfg_id] = int'(cfg_base0);
         m_b1[cfg_id] = int'(cfg_base1); m_w[cfg_id] = int'(cfg_w); m_h[cfg_id] = int'(cfg_h);
         m_x[cfg_id] = int'(cfg_x); m_y[cfg_id] = int'(cfg_y); m_dx[cfg_id] = int'(cfg_dx);
         m_anim[cfg_id] = 0; m_fsel[cfg_id] = 0;
      end
   endtask

   task automatic ref_pixel(output bit h, output int id, output int a);
      int px, py, base;
      px = int'(DrawX); py = int'(DrawY);
      h = 0; id = 0; a = 0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (!h && m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + m_w[i]
                && py >= m_y[i] && py < m_y[i] + m_h[i]) begin
            h = 1; id = i;
            base = (m_fsel[i] != 0) ? m_b1[i] : m_b0[i];
            a = (base + (py - m_y[i]) * m_w[i] + (px - m_x[i])) % (1 << ADDR_W);
         end
      end
   endtask

   // one clock: predict from pre-edge model, compare after the edge, then step model
   task automatic cycle();
      bit h; int id, a;
      int e_req, e_addr, e_id;
      logic [31:0] d;
      if (Reset) begin
         e_req = 0; e_addr = 0; e_id = 0;
         exp_q.delete();
         exp_q.push_back(32'd0);
      end else begin
         ref_pixel(h, id, a);
         if (pix_en && h) begin
            e_req = 1; e_addr = a; e_id = id;
         end else begin
            e_req = 0; e_addr = m_addr; e_id = m_id;
         end
         exp_q.push_back({30'd0, m_req[0], 1'b0} | 32'(m_id << 2));
      end
      @(posedge Clk); #1;
      model_step();
      m_req = e_req; m_addr = e_addr; m_id = e_id;
      d = exp_q.pop_front();
      check_val("rom_req", 32'(rom_req), e_req);
      check_val("rom_addr", 32'(rom_addr), e_addr);
      check_val("hit_id", 32'(hit_id), e_id);
      check_val("hit_valid_d", 32'(hit_valid_d), 32'(d[1]));
      check_val("hit_id_d", 32'(hit_id_d), d >> 2);
      check_val("busy", 32'(busy), (upd_ptr >= 0) ? 1 : 0);
   endtask

   // driver tasks
   task automatic write_cfg(input int id, input int act, input int b0, input int b1,
                            input int w, input int h, input int x, input int y, input int dx);
      cfg_id = 2'(id); cfg_active = 1'(act); cfg_base0 = ADDR_W'(b0); cfg_base1 = ADDR_W'(b1);
      cfg_w = 8'(w); cfg_h = 8'(h); cfg_x = 10'(x); cfg_y = 10'(y); cfg_dx = 4'(dx);
      cfg_we = 1'b1;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic pixel(input int x, input int y);
      DrawX = 10'(x); DrawY = 10'(y); pix_en = 1'b1;
      cycle();
      pix_en = 1'b0;
   endtask

   task automatic do_tick();
      int nb;
      frame_tick = 1'b1; pix_en = 1'b0;
      cycle();
      frame_tick = 1'b0;
      nb = int'(busy);
      repeat (6) begin
         cycle();
         nb += int'(busy);
      end
      check_val("busy_len", nb, NUM_OBJ);
   endtask

   initial begin
      Reset = 1'b1; frame_tick = 1'b0; pix_en = 1'b0; DrawX = '0; DrawY = '0;
      cfg_we = 1'b0; cfg_id = '0; cfg_active = 1'b0; cfg_base0 = '0; cfg_base1 = '0;
      cfg_w = '0; cfg_h = '0; cfg_x = '0; cfg_y = '0; cfg_dx = '0;
      m_addr = 0; m_id = 0; m_req = 0;
      model_reset();
      repeat (3) cycle();
      Reset = 1'b0;
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_addr", 32'(rom_addr), 0);

      // empty screen: no requests, not busy
      for (int y = 0; y < 480; y += 16)
         for (int x = 0; x < 640; x += 16) begin
            DrawX = 10'(x); DrawY = 10'(y); pix_en = 1'b1;
            cycle();
         end
      pix_en = 1'b0;

      // runner in slot 0
      write_cfg(0, 1, RUNNER3_BASE, RUNNER4_BASE, RUNNER_W, RUNNER_H, 100, 200, 0);
      pixel(100, 200); check_val("runner_tl", 32'(rom_addr), 207867);
      pixel(187, 293); check_val("runner_br", 32'(rom_addr), 216138);
      pixel(188, 200); check_val("runner_xend", 32'(rom_req), 0);
      pixel(100, 294); check_val("runner_yend", 32'(rom_req), 0);
      pixel(99, 250);  check_val("runner_xlo", 32'(rom_req), 0);

      // overlap priority
      write_cfg(1, 1, 1000, 2000, 50, 50, 150, 250, 0);
      pixel(160, 260); check_val("ovl_id0", 32'(hit_id), 0);
      write_cfg(0, 0, RUNNER3_BASE, RUNNER4_BASE, RUNNER_W, RUNNER_H, 100, 200, 0);
      pixel(160, 260); check_val("ovl_id1", 32'(hit_id), 1);
      check_val("ovl_addr1", 32'(rom_addr), 1510);

      // animation toggle
      write_cfg(0, 1, RUNNER3_BASE, RUNNER4_BASE, RUNNER_W, RUNNER_H, 100, 200, 0);
      repeat (5) do_tick();
      pixel(100, 200); check_val("anim_f1", 32'(rom_addr), 216139);
      repeat (5) do_tick();
      pixel(100, 200); check_val("anim_f0", 32'(rom_addr), 207867);

      // wrap and exact-zero moves
      write_cfg(3, 1, CLOUD_BASE, CLOUD_BASE, CLOUD_W, CLOUD_H, 2, 10, 3);
      write_cfg(2, 1, CLOUD_BASE, CLOUD_BASE, CLOUD_W, CLOUD_H, 3, 60, 3);
      do_tick();
      pixel(640, 10);
`ifdef SPRITE_WRAP_EN
      check_val("wrap_req", 32'(rom_req), 1);
`else
      check_val("wrap_req", 32'(rom_req), 0);
`endif
      pixel(2, 10); check_val("wrap_old", 32'(rom_req), 0);
      pixel(0, 60); check_val("zero_x_req", 32'(rom_req), 1);
      check_val("zero_x_id", 32'(hit_id), 2);

      // config write collides with update of slot 2; mid-update tick ignored
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0;
      cfg_id = 2'd2; cfg_active = 1'b1; cfg_base0 = ADDR_W'(5000); cfg_base1 = ADDR_W'(6000);
      cfg_w = 8'd20; cfg_h = 8'd20; cfg_x = 10'd300; cfg_y = 10'd400; cfg_dx = 4'd1;
      cfg_we = 1'b1; cycle();
      cfg_we = 1'b0; cycle();
      cycle(); check_val("no_restart", 32'(busy), 0);
      pixel(300, 400); check_val("coll_addr", 32'(rom_addr), 5000);
      repeat (4) do_tick();
      pixel(296, 400); check_val("coll_anim", 32'(rom_addr), 5000);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         int s, px, py;
         if ($urandom_range(0, 29) == 0) begin
            write_cfg($urandom_range(0, 3), ($urandom_range(0, 4) != 0) ? 1 : 0,
                      $urandom_range(0, (1 << ADDR_W) - 1), $urandom_range(0, (1 << ADDR_W) - 1),
                      $urandom_range(1, 120), $urandom_range(1, 120),
                      $urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 15));
         end else begin
            s = $urandom_range(0, 3);
            px = m_x[s] + $urandom_range(0, m_w[s] + 2) - 1;
            py = m_y[s] + $urandom_range(0, m_h[s] + 2) - 1;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            DrawX = 10'(px); DrawY = 10'(py);
            pix_en = ($urandom_range(0, 7) != 0);
            frame_tick = ($urandom_range(0, 39) == 0);
            cycle();
            frame_tick = 1'b0;
         end
      end
      pix_en = 1'b0;

      // reset in the middle of an update
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
      Reset = 1'b1; cycle();
      Reset = 1'b0;
      check_val("rst_mid_busy", 32'(busy), 0);
      check_val("rst_mid_req", 32'(rom_req), 0);
      pixel(100, 200); check_val("rst_mid_slot", 32'(rom_req), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Frame-level sequencer and per-pixel address scheduler for the shared sprite ROM. It holds position and animation state for up to NUM_OBJ sprite objects, such as the runner and the cloud. On each frame tick it steps every object's motion and animation, one object per cycle. On each pixel strobe it selects the highest-priority object covering (DrawX, DrawY) and issues that object's ROM read address. It sits between the VGA timing/host logic and the spriteROM/palette pair in the color mapper.

## Interface
- NUM_OBJ, 4, number of object slots; id 0 has highest priority.
- ANIM_DIV, 5, frame ticks per animation frame toggle.
- SCREEN_W, 640, x value loaded on horizontal wrap.
- ADDR_W, 18, ROM address width.

- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse, once per frame, during vblank.
- pix_en  in  1  pixel strobe; DrawX/DrawY are valid when it is high.
- DrawX, DrawY  in  10 each  current pixel.
- cfg_we  in  1  object configuration write strobe.
- cfg_id  in  $clog2(NUM_OBJ)  slot being written.
- cfg_active  in  1  slot enable.
- cfg_base0, cfg_base1  in  ADDR_W each  sprite start addresses for animation frames 0 and 1.
- cfg_w, cfg_h  in  8 each  sprite width and height.
- cfg_x, cfg_y  in  10 each  top-left position.
- cfg_dx  in  4  leftward speed in pixels per frame tick.
- rom_addr  out  ADDR_W  registered ROM read address.
- rom_req  out  1  rom_addr is valid this cycle.
- hit_id  out  $clog2(NUM_OBJ)  winning object for the rom_addr cycle.
- hit_valid_d  out  1  rom_req delayed one cycle; aligned with ROM data_Out.
- hit_id_d  out  $clog2(NUM_OBJ)  hit_id delayed one cycle.
- busy  out  1  update state machine is running.

## Operation
- Per-slot state: active, base0, base1, w, h, x, y, dx, anim_cnt (counts 0..ANIM_DIV-1), fsel (frame select).
- Config write: loads all fields of slot cfg_id and clears anim_cnt and fsel to 0. It takes effect on the next cycle.
- State machine states are IDLE and UPDATE.
  - IDLE -> UPDATE on frame_tick, with idx=0.
  - In UPDATE, one slot idx is processed per cycle. idx == NUM_OBJ-1 -> IDLE.
  - frame_tick is ignored while in UPDATE.
- Slot update, applied only when the slot is active:
  - If x >= dx: x <= x - dx.
  - Otherwise a wrap event occurs.
  - anim_cnt == ANIM_DIV-1: anim_cnt <= 0 and fsel toggles. Otherwise anim_cnt increments.
  - Inactive slots are passed over unchanged.
- If a config write and an update target the same slot in the same cycle, the config write wins and that slot's update is skipped.
- Hit test per slot, with an exclusive upper bound: active && DrawX >= x && DrawX < x+w && DrawY >= y && DrawY < y+h. Sums are computed at 11 bits, so there is no overflow.
- Priority: the lowest-numbered hitting slot wins.
- Address: (fsel ? base1 : base0) + (DrawY-y)*w + (DrawX-x). The product is 8x8 bits; the sum is truncated to ADDR_W.
- No hit, or pix_en low: rom_req=0, and rom_addr holds its last value.
- Transparency is resolved downstream on the palette index; this block does not fall through to lower-priority slots.

## Timing
- pix_en is sampled in cycle N. rom_addr, rom_req and hit_id are registered at N+1. hit_valid_d and hit_id_d are registered at N+2, aligned with ROM data.
- A full update takes exactly NUM_OBJ cycles after frame_tick. busy is high for exactly those NUM_OBJ cycles.
- The pixel path continues during UPDATE and uses the current registered slot state.
- Reset values:
  - All slots: inactive, every field 0, anim_cnt 0, fsel 0.
  - Outputs: rom_addr 0, rom_req 0, hit_id 0, hit_valid_d 0, hit_id_d 0, busy 0.
  - State machine: IDLE.
- Reset asserted mid-UPDATE aborts the update at the next edge, with everything at reset values.

## Configuration
- SPRITE_WRAP_EN defined: a wrap event loads x <= SCREEN_W and the slot stays active. This gives the continuous scrolling used for clouds.
- SPRITE_WRAP_EN undefined: a wrap event clears active, so the slot disappears until it is rewritten.
- Animation advances in both builds.

## Structure
- Package sprite_pkg holds:
  - ADDR_W.
  - The sprite base and size constants: runner3 207867, runner4 216139, 88x94; cloud 44420, 92x27.
  - typedef obj_t, the slot record.
- Sub-module sprite_hit: combinational hit test plus offset computation for one slot, instantiated NUM_OBJ times.

## Test plan
- Reset, then drive pix_en over the whole screen -> rom_req stays 0 and busy stays 0.
- Slot 0 = runner (base0 207867, base1 216139, 88x94, at 100,200). Pixel (100,200) -> rom_addr 207867 at N+1. Pixel (187,293) -> 207867+93*88+87=216138. Pixel (188,200) -> no rom_req.
- Slot 0 and slot 1 overlap -> hit_id 0. Disable slot 0 -> hit_id 1.
- ANIM_DIV=5: 5 frame_ticks -> fsel=1 and addresses are based on 216139. After 10 ticks -> back to 207867. busy is high for exactly 4 cycles per tick.
- Cloud with x=2, dx=3, one tick:
  - With SPRITE_WRAP_EN -> x=640, active.
  - Without SPRITE_WRAP_EN -> inactive.
  - Separately, x=3 -> x=0 in both builds.
- Config write to slot 2 during UPDATE with idx=2 -> slot 2 holds the written values, anim_cnt 0. A frame_tick during UPDATE does not restart the update.
